// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for the HI/LO unit.
// Multiply-accumulate opcodes are decoded only when MD_MADD_EN is defined.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mult(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request/result bundle of the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_arith.sv
// md_arith: combinational result generator producing the pending {HI,LO}.
// Accumulate opcodes are built only when MD_MADD_EN is defined.
module md_arith
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] s_a, s_b, s_prod;
  logic        [2*WIDTH-1:0] u_a, u_b, u_prod;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   div_safe, u_quo, u_rem;
  logic signed [WIDTH-1:0]   s_num, s_den, s_quo, s_rem;
`ifdef MD_MADD_EN
  logic        [2*WIDTH-1:0] acc;
`endif

  always_comb begin
    s_a    = {{WIDTH{rs_i[WIDTH-1]}}, rs_i};
    s_b    = {{WIDTH{rt_i[WIDTH-1]}}, rt_i};
    s_prod = s_a * s_b;
    u_a    = {{WIDTH{1'b0}}, rs_i};
    u_b    = {{WIDTH{1'b0}}, rt_i};
    u_prod = u_a * u_b;

    // Zero divisor and MIN/-1 are resolved explicitly; a divisor of 1 keeps the divider defined.
    div_zero = (rt_i == '0);
    div_ovf  = (rs_i == MOST_NEG) && (rt_i == '1);
    div_safe = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_i;
    s_num    = rs_i;
    s_den    = div_safe;
    s_quo    = s_num / s_den;
    s_rem    = s_num % s_den;
    u_quo    = rs_i / div_safe;
    u_rem    = rs_i % div_safe;
`ifdef MD_MADD_EN
    acc      = {hi_i, lo_i};
`endif

    hi_o = hi_i;
    lo_o = lo_i;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = s_prod;
      MD_MULTU: {hi_o, lo_o} = u_prod;
      MD_DIV: begin
        if (div_ovf) begin
          hi_o = '0;
          lo_o = MOST_NEG;
        end else if (!div_zero) begin
          hi_o = s_rem;
          lo_o = s_quo;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          hi_o = u_rem;
          lo_o = u_quo;
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  {hi_o, lo_o} = acc + s_prod;
      MD_MADDU: {hi_o, lo_o} = acc + u_prod;
      MD_MSUB:  {hi_o, lo_o} = acc - s_prod;
      MD_MSUBU: {hi_o, lo_o} = acc - u_prod;
`endif
      default: begin
        hi_o = hi_i;
        lo_o = lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: result computed at launch, committed after a latency.
// Optional multiply-accumulate opcodes are enabled by defining MD_MADD_EN.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N   = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N    = CW'(DIV_CYCLES);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] phi_q, plo_q;
  logic [WIDTH-1:0] phi_d, plo_d;
  logic             accept;

  md_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .op_i (md.md_op),
    .rs_i (md.rs_val),
    .rt_i (md.rt_val),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (phi_d),
    .lo_o (plo_d)
  );

  assign accept = md.start & ~busy_q & ~md.cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (md.md_op == MD_MTHI) hi_q <= md.rs_val;
            if (md.md_op == MD_MTLO) lo_q <= md.rs_val;
            if (md_is_mult(md.md_op) || md_is_div(md.md_op)) begin
              phi_q   <= phi_d;
              plo_q   <= plo_d;
              cnt_q   <= md_is_div(md.md_op) ? DIV_N : MULT_N;
              busy_q  <= 1'b1;
              state_q <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= phi_q;
            lo_q    <= plo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, commits checked by a separate monitor.
module tb_mult_div_unit;
  import md_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic [31:0] cur_hi, cur_lo;
  logic busy_prev;
  int unsigned run_len;

  mult_div_unit_if #(.WIDTH(32)) mif ();

  mult_div_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: while busy, HI/LO must hold; on the busy falling edge, pop and compare.
  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      run_len   = 0;
    end else begin
      if (mif.busy) begin
        run_len++;
        chk("hold_hi", mif.hi, cur_hi);
        chk("hold_lo", mif.lo, cur_lo);
      end else if (busy_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got commit hi=0x%08h lo=0x%08h expected none", mif.hi, mif.lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_hi", mif.hi, e.hi);
          chk("commit_lo", mif.lo, e.lo);
          chk("busy_len", run_len, e.cyc);
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
        run_len = 0;
      end
      busy_prev = mif.busy;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cnl);
    mif.start  = 1'b1;
    mif.md_op  = op;
    mif.rs_val = a;
    mif.rt_val = b;
    mif.cancel = cnl;
    @(posedge clk);
    #1;
    mif.start  = 1'b0;
    mif.cancel = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!mif.busy && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got busy=%0b pending=%0d expected idle", mif.busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    issue(op, v, 32'h0, 1'b0);
    if (op == MD_MTHI) cur_hi = v; else cur_lo = v;
    @(negedge clk);
    #1;
    chk("mt_busy", {31'b0, mif.busy}, 32'h0);
    if (op == MD_MTHI) chk("mthi", mif.hi, v); else chk("mtlo", mif.lo, v);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input int unsigned cyc);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = cyc;
    sb.push_back(e);
    issue(op, a, b, 1'b0);
    wait_done();
  endtask

  task automatic idle_check(input string name);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk({name, "_busy"}, {31'b0, mif.busy}, 32'h0);
    end
    chk({name, "_hi"}, mif.hi, cur_hi);
    chk({name, "_lo"}, mif.lo, cur_lo);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cur_hi     = '0;
    cur_lo     = '0;
    busy_prev  = 1'b0;
    run_len    = 0;
    reset      = 1'b1;
    mif.start  = 1'b0;
    mif.cancel = 1'b0;
    mif.md_op  = '0;
    mif.rs_val = '0;
    mif.rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, mif.busy}, 32'h0);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);

    mt(MD_MTHI, 32'h0000_1234);
    mt(MD_MTLO, 32'h0000_5678);

    run(MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run(MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        10);
    run(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 10);
    run(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10);

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    run(MD_DIV, 32'd55, 32'd0, 32'h11, 32'h22, 10);

    issue(MD_MULT, 32'd5, 32'd6, 1'b1);
    idle_check("cancel_start");

    begin
      exp_t e;
      e.hi  = 32'd2;
      e.lo  = 32'd14;
      e.cyc = 10;
      sb.push_back(e);
      issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      mif.cancel = 1'b1;
      @(posedge clk);
      #1;
      mif.cancel = 1'b0;
      wait_done();
    end

    issue(4'd12, 32'hDEAD_BEEF, 32'd3, 1'b0);
    idle_check("noop");

    mt(MD_MTHI, 32'h0);
    mt(MD_MTLO, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run(MD_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 5);
`else
    issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
    idle_check("maddu_off");
`endif

    mt(MD_MTHI, 32'hAA);
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, mif.busy}, 32'h0);
    chk("arst_hi", mif.hi, 32'h0);
    chk("arst_lo", mif.lo, 32'h0);
    sb.delete();
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("post_rst_busy", {31'b0, mif.busy}, 32'h0);
    chk("post_rst_hi", mif.hi, 32'h0);
    chk("post_rst_lo", mif.lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle HI/LO multiply/divide unit for the pipelined MIPS core's EX stage. It is the successor to the fixed 32-bit MultDiv block, with configurable operand width and independent multiply and divide latencies. It adds defined divide-by-zero behaviour, and can optionally add multiply-accumulate operations. The stall unit watches `busy`, and the interrupt controller suppresses launches through `cancel`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, default 5: busy cycles for multiply-class operations; must be ≥ 1.
- `DIV_CYCLES`, default 10: busy cycles for divide operations; must be ≥ 1.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: launch request for the operation in the EX stage.
- `md_op`, input, 4: operation code (see Operation).
- `rs_val`, input, `WIDTH`: forwarded rs operand.
- `rt_val`, input, `WIDTH`: forwarded rt operand.
- `cancel`, input, 1: interrupt or exception accepted this cycle (IntReq | ExcReq); blocks any launch.
- `busy`, output, 1: a multi-cycle operation is in progress.
- `hi`, output, `WIDTH`: committed HI register.
- `lo`, output, `WIDTH`: committed LO register.

## Operation
- Opcodes:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU (only when the feature is compiled in).
  - All other codes are no-ops.
- Accept condition: `start & ~busy & ~cancel` sampled at a rising edge.
  - A `start` while `busy` is ignored; the stall unit guarantees this does not occur.
  - A `start` together with `cancel` is dropped entirely: no state change and `busy` stays low.
- MTHI / MTLO: `hi`, or `lo`, takes `rs_val` at the accepting edge. `busy` is never raised.
- Multi-cycle operations: at the accepting edge the result is computed from `rs_val`/`rt_val` and stored in a pending {HI, LO} register. `busy` is set and a down-counter is loaded with the operation's latency.
- MULT / MULTU: 2·`WIDTH`-bit signed or unsigned product; HI = upper half, LO = lower half.
- DIV / DIVU: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Signed overflow case: DIV of the most-negative value by −1 gives LO = most-negative value, HI = 0.
- Divide by zero (`rt_val` = 0): the operation still occupies `DIV_CYCLES`, then commits with HI and LO unchanged. No exception is raised.
- MADD / MSUB: {HI,LO} ± signed product, computed modulo 2^(2·`WIDTH`). The U variants use the unsigned product.
- FSM:
  - IDLE → RUN on an accepted multi-cycle operation.
  - RUN → IDLE when the counter reaches 1; pending is committed to `hi`/`lo` at that same edge.
- `cancel` during RUN has no effect. The running operation belongs to an instruction already past EX and completes normally.
- Reset clears `hi`, `lo`, the pending register and the counter, and sets `busy` = 0, including mid-operation. The in-flight result is discarded.

## Timing
- Accept at edge t.
- `busy` = 1 during cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- `hi`/`lo` change at edge t+N and read new values from cycle t+N onward.
- `busy` is 0 in the cycle where new values first appear, so a back-to-back operation may be accepted at edge t+N.
- `hi`/`lo` hold their old values throughout RUN.
- MTHI/MTLO take effect at the next edge (latency 1, zero busy cycles).
- Counter width is `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`.

## Configuration
- Macro `MD_MADD_EN`.
  - Defined: opcodes 6–9 are implemented with `MULT_CYCLES` latency.
  - Undefined: opcodes 6–9 are no-ops. They are never accepted, `busy` stays low, and no accumulate adder is synthesised.

## Structure
- Shared package `md_pkg` holds the opcode localparams `MD_MULT` … `MD_MSUBU` and the FSM state enum {`MD_IDLE`, `MD_RUN`}.
- One natural sub-module, `md_arith`: purely combinational. It takes op, operands and current {HI,LO} and returns the pending {HI,LO}, including the divide-by-zero hold and overflow rules. The parent holds the FSM, counter and registers.

## Test plan
- MULT, rs = −3, rt = 7, defaults: `busy` high for 5 cycles, then `hi` = 0xFFFFFFFF and `lo` = 0xFFFFFFEB; `hi`/`lo` stay at old values while busy.
- DIVU, rs = 100, rt = 7: after 10 busy cycles, `lo` = 14 and `hi` = 2. Then DIV, rs = −7, rt = 2 gives `lo` = −3, `hi` = −1.
- DIV by zero with `hi`/`lo` preloaded to 0x11/0x22 via MTHI/MTLO: 10 busy cycles, then values remain 0x11/0x22.
- `start` MULT together with `cancel` = 1: `busy` stays 0 and `hi`/`lo` are unchanged. Then `cancel` pulsed during a running DIVU: the result still commits on time.
- Reset asserted asynchronously at cycle 3 of a MULT: `busy`, `hi` and `lo` all go to 0 immediately, and nothing commits afterwards.
- With `MD_MADD_EN`: `hi`/`lo` = 0/0xFFFFFFFF, then MADDU 1×1 gives `hi` = 1, `lo` = 0. Without the macro, the same stimulus leaves the values unchanged and `busy` = 0.
